// File: rtl/tron_pkg.sv
// Shared constants and FSM encoding for the Tron round scorer.
package tron_pkg;

    localparam logic [2:0] GS_MENU  = 3'd0;
    localparam logic [2:0] GS_PAUSE = 3'd1;

    typedef enum logic [1:0] {
        ARM        = 2'd0,
        PLAY       = 2'd1,
        ROUND_END  = 2'd2,
        MATCH_OVER = 2'd3
    } score_state_t;

endpackage

// File: rtl/round_scorer_crash_edge_det.sv
// Registered rising-edge detector for per-player crash levels.
// Clearing forgets the crash history, so a level still high after a clear
// shows up as a fresh edge.
module crash_edge_det #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] lvl,
    output logic [WIDTH-1:0] ev
);

    logic [WIDTH-1:0] prev_d, prev_q;

    // Next history value is simply the current level.
    always_comb begin
        prev_d = lvl;
    end

    // History register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) prev_q <= '0;
        else     prev_q <= prev_d;
    end

    assign ev = lvl & ~prev_q;

endmodule

// File: rtl/round_scorer.sv
// Round/match score keeper for NUM_PLAYERS light-cycles.
// Survivors of each round score one point (saturating at WIN_SCORE);
// an all-crashed round is a draw. reset_round pulses RESET_CYCLES wide
// after every round end, and the winners are latched once anyone hits
// WIN_SCORE.
// Optional: define SCORE_LAST_ROUND_EN to add the last_round_scorers port.
module round_scorer
    import tron_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int WIN_SCORE    = 3,
    parameter int SCORE_W      = $clog2(WIN_SCORE + 1),
    parameter int RESET_CYCLES = 4
) (
    input  logic                           Clk,
    input  logic                           Reset_Score,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS-1:0]         crash,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           reset_round,
    output logic                           draw_round,
    output logic [NUM_PLAYERS-1:0]         win,
`ifdef SCORE_LAST_ROUND_EN
    output logic [NUM_PLAYERS-1:0]         last_round_scorers,
`endif
    output logic                           match_over
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RESET_CYCLES);

    logic clear;
    logic [NUM_PLAYERS-1:0] ev;
    logic any_win;

    score_state_t state_d, state_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_d, score_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic reset_round_d, reset_round_q;
    logic draw_round_d, draw_round_q;
    logic [NUM_PLAYERS-1:0] win_d, win_q;
    logic match_over_d, match_over_q;
`ifdef SCORE_LAST_ROUND_EN
    logic [NUM_PLAYERS-1:0] lrs_d, lrs_q;
`endif

    assign clear = Reset_Score || (Game_State == GS_MENU);

    crash_edge_det #(.WIDTH(NUM_PLAYERS)) u_edge (
        .clk (Clk),
        .clr (clear),
        .lvl (crash),
        .ev  (ev)
    );

    // Does any player currently hold the winning score?
    always_comb begin
        any_win = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (score_q[i] == WIN_VAL) any_win = 1'b1;
    end

    // Next-state and next-output computation for the scoring FSM.
    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        cnt_d         = cnt_q;
        reset_round_d = reset_round_q;
        draw_round_d  = 1'b0;
        win_d         = win_q;
        match_over_d  = match_over_q;
`ifdef SCORE_LAST_ROUND_EN
        lrs_d         = lrs_q;
`endif
        case (state_q)
            // Wait for every crash level to drop so stale levels never score.
            ARM: begin
                if (crash == '0) state_d = PLAY;
            end
            PLAY: begin
                if (Game_State != GS_PAUSE && ev != '0) begin
                    if (&crash) begin
                        draw_round_d = 1'b1;
`ifdef SCORE_LAST_ROUND_EN
                        lrs_d = '0;
`endif
                    end else begin
                        for (int i = 0; i < NUM_PLAYERS; i++)
                            if (!crash[i] && score_q[i] != WIN_VAL)
                                score_d[i] = score_q[i] + SCORE_W'(1);
`ifdef SCORE_LAST_ROUND_EN
                        lrs_d = ~crash;
`endif
                    end
                    reset_round_d = 1'b1;
                    cnt_d         = CNT_LOAD;
                    state_d       = ROUND_END;
                end
            end
            // Pulse runs regardless of PAUSE; cnt_q counts remaining high cycles.
            ROUND_END: begin
                if (cnt_q <= CNT_W'(1)) begin
                    reset_round_d = 1'b0;
                    cnt_d         = '0;
                    if (any_win) begin
                        state_d      = MATCH_OVER;
                        match_over_d = 1'b1;
                        for (int i = 0; i < NUM_PLAYERS; i++)
                            win_d[i] = (score_q[i] == WIN_VAL);
                    end else begin
                        state_d = ARM;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MATCH_OVER: begin
                state_d = MATCH_OVER;
            end
            default: state_d = ARM;
        endcase
    end

    // State and output registers; a clear wins over everything.
    always_ff @(posedge Clk) begin
        if (clear) begin
            state_q       <= ARM;
            score_q       <= '0;
            cnt_q         <= '0;
            reset_round_q <= 1'b0;
            draw_round_q  <= 1'b0;
            win_q         <= '0;
            match_over_q  <= 1'b0;
`ifdef SCORE_LAST_ROUND_EN
            lrs_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            cnt_q         <= cnt_d;
            reset_round_q <= reset_round_d;
            draw_round_q  <= draw_round_d;
            win_q         <= win_d;
            match_over_q  <= match_over_d;
`ifdef SCORE_LAST_ROUND_EN
            lrs_q         <= lrs_d;
`endif
        end
    end

    assign score       = score_q;
    assign reset_round = reset_round_q;
    assign draw_round  = draw_round_q;
    assign win         = win_q;
    assign match_over  = match_over_q;
`ifdef SCORE_LAST_ROUND_EN
    assign last_round_scorers = lrs_q;
`endif

endmodule
